// File: rtl/acc_mcu_core.sv
// acc_mcu_core: width-generic accumulator CPU with on-chip word memory, a
// fetch/execute FSM, carry flag and a full-state scan chain.
// Optional feature macro: ACC_MCU_IO_EN maps address MEM_DEPTH-1 to button
// (read) / LED register (write) and appends the LED register to the chain.
`timescale 1ns/1ps

module acc_mcu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int IO_W   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_enable,
  input  logic            scan_in,
  output logic            scan_out,
  input  logic            proc_en,
  output logic            halt,
  input  logic            btn_in,
  output logic [IO_W-1:0] led_out
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
`ifdef ACC_MCU_IO_EN
  localparam int NWORDS = MEM_DEPTH - 1;
`else
  localparam int NWORDS = MEM_DEPTH;
`endif

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC  = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_BZ  = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] acc_q;
  logic              c_q;
  logic [DATA_W-1:0] mem [NWORDS];

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   add_res;
  logic [DATA_W:0]   sub_res;

`ifdef ACC_MCU_IO_EN
  logic [IO_W-1:0] led_q;
  localparam logic [ADDR_W-1:0] IO_ADDR = '1;
`endif

  // Shared read port: PC during fetch, instruction operand otherwise.
  always_comb begin
    opcode  = ir_q[DATA_W-1 -: 3];
    operand = ir_q[ADDR_W-1:0];
    rd_addr = (state_q == ST_FETCH) ? pc_q : operand;
`ifdef ACC_MCU_IO_EN
    if (rd_addr == IO_ADDR) begin
      rd_data = {{(DATA_W-1){1'b0}}, btn_in};
    end else begin
      rd_data = mem[rd_addr];
    end
`else
    rd_data = mem[rd_addr];
`endif
    add_res = {1'b0, acc_q} + {1'b0, rd_data};
    sub_res = {1'b0, acc_q} - {1'b0, rd_data};
  end

  // Architectural state: reset, else scan shift, else fetch/execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        mem[i] <= '0;
      end
`ifdef ACC_MCU_IO_EN
      led_q   <= '0;
`endif
    end else if (scan_enable) begin
      state_q <= {state_q[0], scan_in};
      pc_q    <= {pc_q[ADDR_W-2:0], state_q[1]};
      ir_q    <= {ir_q[DATA_W-2:0], pc_q[ADDR_W-1]};
      acc_q   <= {acc_q[DATA_W-2:0], ir_q[DATA_W-1]};
      c_q     <= acc_q[DATA_W-1];
      mem[0]  <= {mem[0][DATA_W-2:0], c_q};
      for (int i = 1; i < NWORDS; i++) begin
        mem[i] <= {mem[i][DATA_W-2:0], mem[i-1][DATA_W-1]};
      end
`ifdef ACC_MCU_IO_EN
      led_q   <= {led_q[IO_W-2:0], mem[NWORDS-1][DATA_W-1]};
`endif
    end else if (proc_en) begin
      case (state_q)
        ST_FETCH: begin
          ir_q    <= rd_data;
          pc_q    <= pc_q + 1'b1;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q <= ST_FETCH;
          case (opcode)
            OP_LDA: acc_q <= rd_data;
            OP_STA: begin
`ifdef ACC_MCU_IO_EN
              if (operand == IO_ADDR) begin
                led_q <= acc_q[IO_W-1:0];
              end else begin
                mem[operand] <= acc_q;
              end
`else
              mem[operand] <= acc_q;
`endif
            end
            OP_ADD: {c_q, acc_q} <= add_res;
            OP_SUB: {c_q, acc_q} <= sub_res;
            OP_AND: acc_q <= acc_q & rd_data;
            OP_BZ: begin
              if (acc_q == '0) begin
                pc_q <= operand;
              end
            end
            OP_JMP: pc_q <= operand;
            OP_HLT: state_q <= ST_HALT;
            default: ;
          endcase
        end
        // HALT and the scan-only encoding 2'b11 are absorbing.
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only.
  assign halt = state_q[1];

`ifdef ACC_MCU_IO_EN
  assign led_out  = led_q;
  assign scan_out = led_q[IO_W-1];
`else
  logic unused_btn;
  assign unused_btn = btn_in;
  assign led_out    = '0;
  assign scan_out   = mem[NWORDS-1][DATA_W-1];
`endif

endmodule

// File: tb/tb_acc_mcu_core.sv
// Directed self-checking bench for acc_mcu_core (default parameters).
// Whole-state checks go through the scan chain; layout of the image vector
// (bit 0 nearest scan_in): state, PC, IR, ACC, C, M[0].., LED.
`timescale 1ns/1ps

module tb_acc_mcu_core;

  localparam int MAXL = 280;
`ifdef ACC_MCU_IO_EN
  localparam int L = 279;
`else
  localparam int L = 280;
`endif
  localparam int ST  = 0;
  localparam int PC  = 2;
  localparam int IR  = 7;
  localparam int AC  = 15;
  localparam int CY  = 23;
  localparam int MEM = 24;
  localparam int LED = 272;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;
  logic       proc_en;
  logic       halt;
  logic       btn_in;
  logic [6:0] led_out;

  acc_mcu_core dut (
    .clk         (clk),
    .rst         (rst),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .proc_en     (proc_en),
    .halt        (halt),
    .btn_in      (btn_in),
    .led_out     (led_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [MAXL-1:0] obs,
                       input logic [MAXL-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAXL-1:0] mask(input logic [MAXL-1:0] v);
    logic [MAXL-1:0] r;
    r = v;
    for (int i = L; i < MAXL; i++) r[i] = 1'b0;
    return r;
  endfunction

  // Called at a negedge; shifts L bits, returns the old chain contents.
  task automatic scan_xfer(input logic [MAXL-1:0] din, output logic [MAXL-1:0] dout);
    dout = '0;
    scan_enable = 1'b1;
    for (int i = 0; i < L; i++) begin
      scan_in = din[L-1-i];
      dout[L-1-i] = scan_out;
      @(posedge clk);
      @(negedge clk);
    end
    scan_enable = 1'b0;
    scan_in = 1'b0;
  endtask

  // Load image, run to halt (optionally stalling 5 cycles), read back state.
  task automatic run_prog(input logic [MAXL-1:0] din, input int stall_at,
                          output int cycles, output logic halt_seen,
                          output logic [6:0] led_seen, output logic [MAXL-1:0] dout);
    logic [MAXL-1:0] dummy;
    scan_xfer(din, dummy);
    proc_en = 1'b1;
    cycles = 0;
    while (!halt && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == stall_at) begin
        proc_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cycles += 5;
        proc_en = 1'b1;
      end
    end
    halt_seen = halt;
    led_seen  = led_out;
    @(negedge clk);
    proc_en = 1'b0;
    scan_xfer('0, dout);
  endtask

  logic [MAXL-1:0] img, got, expv, rnd;
  logic [6:0]      led_seen;
  logic            halt_seen;
  int              cyc;

  initial begin
    rst = 1'b1;
    scan_enable = 1'b0;
    scan_in = 1'b0;
    proc_en = 1'b0;
    btn_in = 1'b0;
    #2 rst = 1'b0;
    #3;
    check("rst_halt", halt, 0);
    check("rst_led", led_out, 0);
    check("rst_scan_out", scan_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    scan_xfer('0, got);
    check("rst_chain", got, 0);

    // LDA 4; ADD 5; STA 31; HLT with M4=5, M5=3 -> 8 at address 31.
    img = '0;
    img[MEM+0*8 +: 8] = 8'h04;
    img[MEM+1*8 +: 8] = 8'h45;
    img[MEM+2*8 +: 8] = 8'h3F;
    img[MEM+3*8 +: 8] = 8'hE0;
    img[MEM+4*8 +: 8] = 8'h05;
    img[MEM+5*8 +: 8] = 8'h03;
    expv = img;
    expv[ST +: 2] = 2'b10;
    expv[PC +: 5] = 5'd4;
    expv[IR +: 8] = 8'hE0;
    expv[AC +: 8] = 8'h08;
`ifdef ACC_MCU_IO_EN
    expv[LED +: 7] = 7'h08;
`else
    expv[MEM+31*8 +: 8] = 8'h08;
`endif
    run_prog(img, -1, cyc, halt_seen, led_seen, got);
    check("prog_cycles", cyc, 8);
    check("prog_halt", halt_seen, 1);
`ifdef ACC_MCU_IO_EN
    check("prog_led", led_seen, 7'h08);
`else
    check("prog_led_tied", led_seen, 0);
`endif
    check("prog_state", got, expv);

    run_prog(img, 3, cyc, halt_seen, led_seen, got);
    check("stall_cycles", cyc, 13);
    check("stall_state", got, expv);

    // LDA 10; ADD 11; HLT: 0xFF + 0x01 -> 0x00 carry 1.
    img = '0;
    img[MEM+0*8 +: 8] = 8'h0A;
    img[MEM+1*8 +: 8] = 8'h4B;
    img[MEM+2*8 +: 8] = 8'hE0;
    img[MEM+10*8 +: 8] = 8'hFF;
    img[MEM+11*8 +: 8] = 8'h01;
    run_prog(img, -1, cyc, halt_seen, led_seen, got);
    check("add_acc", got[AC +: 8], 8'h00);
    check("add_c", got[CY], 1);
    check("add_pc", got[PC +: 5], 5'd3);

    // 0x00 - 0x01 -> 0xFF borrow 1.
    img[MEM+1*8 +: 8] = 8'h6B;
    img[MEM+10*8 +: 8] = 8'h00;
    run_prog(img, -1, cyc, halt_seen, led_seen, got);
    check("sub_acc", got[AC +: 8], 8'hFF);
    check("sub_c", got[CY], 1);

    // 0xF0 & 0x3C -> 0x30, preloaded carry stays 1.
    img[MEM+1*8 +: 8] = 8'h8B;
    img[MEM+10*8 +: 8] = 8'hF0;
    img[MEM+11*8 +: 8] = 8'h3C;
    img[CY] = 1'b1;
    run_prog(img, -1, cyc, halt_seen, led_seen, got);
    check("and_acc", got[AC +: 8], 8'h30);
    check("and_c", got[CY], 1);

    // BZ 10 with ACC=0 -> HLT at 10, PC ends at 11.
    img = '0;
    img[MEM+0*8 +: 8] = 8'hAA;
    img[MEM+1*8 +: 8] = 8'hE0;
    img[MEM+10*8 +: 8] = 8'hE0;
    run_prog(img, -1, cyc, halt_seen, led_seen, got);
    check("bz_taken_pc", got[PC +: 5], 5'd11);
    check("bz_taken_cycles", cyc, 4);

    img[AC +: 8] = 8'h01;
    run_prog(img, -1, cyc, halt_seen, led_seen, got);
    check("bz_not_taken_pc", got[PC +: 5], 5'd2);
    check("bz_not_taken_acc", got[AC +: 8], 8'h01);

    // JMP 31 from PC=30; word 31 reads 0x01 (LDA 1), PC wraps, HLT at 0.
    img = '0;
    img[PC +: 5] = 5'd30;
    img[MEM+30*8 +: 8] = 8'hDF;
    img[MEM+0*8 +: 8] = 8'hE0;
    img[MEM+1*8 +: 8] = 8'h55;
`ifndef ACC_MCU_IO_EN
    img[MEM+31*8 +: 8] = 8'h01;
`endif
    btn_in = 1'b1;
    run_prog(img, -1, cyc, halt_seen, led_seen, got);
    btn_in = 1'b0;
    check("jmp_acc", got[AC +: 8], 8'h55);
    check("jmp_pc", got[PC +: 5], 5'd1);
    check("jmp_ir", got[IR +: 8], 8'hE0);
    check("jmp_cycles", cyc, 6);

    // Reset asserted in the middle of an EXEC cycle.
    img = '0;
    img[MEM+0*8 +: 8] = 8'h04;
    img[MEM+1*8 +: 8] = 8'hE0;
    img[MEM+4*8 +: 8] = 8'hA5;
    scan_xfer(img, got);
    proc_en = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_exec_halt", halt, 0);
    check("rst_exec_led", led_out, 0);
    check("rst_exec_scan_out", scan_out, 0);
    @(negedge clk);
    rst = 1'b1;
    proc_en = 1'b0;
    scan_xfer('0, got);
    check("rst_exec_chain", got, 0);

    // Reset asserted while shifting an all-ones image.
    scan_xfer(mask('1), got);
    check("ones_scan_out", scan_out, 1);
    check("ones_halt", halt, 1);
    scan_enable = 1'b1;
    scan_in = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_scan_halt", halt, 0);
    check("rst_scan_led", led_out, 0);
    check("rst_scan_scan_out", scan_out, 0);
    @(negedge clk);
    rst = 1'b1;
    scan_enable = 1'b0;
    scan_xfer('0, got);
    check("rst_scan_chain", got, 0);

    // Random state round trip through the chain.
    rnd = '0;
    for (int i = 0; i < MAXL; i++) rnd[i] = 1'($urandom_range(0, 1));
    rnd = mask(rnd);
    scan_xfer(rnd, got);
`ifdef ACC_MCU_IO_EN
    check("rand_led", led_out, rnd[LED +: 7]);
`else
    check("rand_led_tied", led_out, 0);
`endif
    check("rand_halt", halt, rnd[ST+1]);
    scan_xfer('0, got);
    check("rand_roundtrip", got, rnd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
